// File: rtl/branch_predict_tage_lite.sv
// Tournament branch predictor: tagged BTB, local BHT/PHT, gshare global PHT with speculative GHR.
// Optional return address stack enabled by defining BRANCH_PREDICT_RAS_EN.
module branch_predict_tage_lite #(
  parameter int S_PC      = 6,
  parameter int S_BH      = 6,
  parameter int S_GPHT    = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            if_valid,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_instr,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  output logic            pred_local,
  output logic            pred_global,
  output logic [S_BH-1:0] pred_ghr,
  input  logic            ex_valid,
  input  logic [31:0]     ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  input  logic            ex_pred_local,
  input  logic            ex_pred_global,
  input  logic [S_BH-1:0] ex_ghr,
  output logic            mispredict,
  output logic [31:0]     redirect_pc
);

  localparam int N_PC   = 1 << S_PC;
  localparam int N_LPHT = 1 << (S_PC + S_BH);
  localparam int N_GPHT = 1 << S_GPHT;
  localparam int TAG_W  = 30 - S_PC;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic              btb_vld_q [N_PC];
  logic [TAG_W-1:0]  btb_tag_q [N_PC];
  logic [31:0]       btb_tgt_q [N_PC];
  logic [S_BH-1:0]   bht_q     [N_PC];
  logic [1:0]        tour_q    [N_PC];
  logic [1:0]        lpht_q    [N_LPHT];
  logic [1:0]        gpht_q    [N_GPHT];
  logic [S_BH-1:0]   ghr_q, ghr_d;

  logic [S_PC-1:0]        if_idx, ex_idx;
  logic [S_PC+S_BH-1:0]   if_lidx, ex_lidx;
  logic [S_GPHT-1:0]      if_gidx, ex_gidx;
  logic                   if_hit, if_br, if_jmp, ex_br, ex_jmp;
  logic                   btb_we, br_we;
  logic [S_BH-1:0]        bht_d;
  logic [1:0]             lpht_d, gpht_d, tour_d;
  logic                   ras_hit;
  logic [31:0]            ras_top;
  logic                   taken_c;
  logic [31:0]            tgt_c;

  assign if_idx  = if_pc[S_PC+1:2];
  assign if_hit  = btb_vld_q[if_idx] && (btb_tag_q[if_idx] == if_pc[31:S_PC+2]);
  assign if_lidx = {if_idx, bht_q[if_idx]};
  assign if_gidx = if_pc[S_GPHT+1:2] ^ S_GPHT'(ghr_q);
  assign if_br   = (if_instr[6:0] == OP_BR);
  assign if_jmp  = (if_instr[6:0] == OP_JAL) || (if_instr[6:0] == OP_JALR);

  assign ex_idx  = ex_pc[S_PC+1:2];
  assign ex_lidx = {ex_idx, bht_q[ex_idx]};
  assign ex_gidx = ex_pc[S_GPHT+1:2] ^ S_GPHT'(ex_ghr);
  assign ex_br   = (ex_opcode == OP_BR);
  assign ex_jmp  = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);

  assign pred_ghr = ghr_q;

  // IF: zero-latency direction/target; a RAS return overrides the BTB
  always_comb begin
    pred_local  = lpht_q[if_lidx][1];
    pred_global = gpht_q[if_gidx][1];
    taken_c     = 1'b0;
    tgt_c       = btb_tgt_q[if_idx];
    if (if_valid && if_hit) begin
      if (if_jmp)     taken_c = 1'b1;
      else if (if_br) taken_c = tour_q[if_idx][1] ? pred_global : pred_local;
    end
    if (ras_hit) begin
      taken_c = 1'b1;
      tgt_c   = ras_top;
    end
    pred_taken  = taken_c;
    pred_target = taken_c ? tgt_c : if_pc + 32'd4;
  end

  // EX: resolve, compute table write values and GHR next state
  always_comb begin
    mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    btb_we      = ex_valid && !stall && (ex_jmp || (ex_br && ex_taken));
    br_we       = ex_valid && !stall && ex_br;
    bht_d       = {bht_q[ex_idx][S_BH-2:0], ex_taken};
    lpht_d      = sat2(lpht_q[ex_lidx], ex_taken);
    gpht_d      = sat2(gpht_q[ex_gidx], ex_taken);
    tour_d      = tour_q[ex_idx];
    if ((ex_pred_global == ex_taken) && (ex_pred_local != ex_taken))
      tour_d = sat2(tour_q[ex_idx], 1'b1);
    else if ((ex_pred_local == ex_taken) && (ex_pred_global != ex_taken))
      tour_d = sat2(tour_q[ex_idx], 1'b0);
    // checkpoint repair wins over the speculative shift from IF
    ghr_d = ghr_q;
    if (!stall) begin
      if (mispredict && ex_br)             ghr_d = {ex_ghr[S_BH-2:0], ex_taken};
      else if (mispredict && ex_jmp)       ghr_d = ex_ghr;
      else if (if_valid && if_br && if_hit) ghr_d = {ghr_q[S_BH-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
      for (int i = 0; i < N_PC; i++) begin
        btb_vld_q[i] <= 1'b0;
        bht_q[i]     <= '0;
        tour_q[i]    <= 2'b01;
      end
      for (int i = 0; i < N_LPHT; i++) lpht_q[i] <= 2'b01;
      for (int i = 0; i < N_GPHT; i++) gpht_q[i] <= 2'b01;
    end else begin
      ghr_q <= ghr_d;
      if (btb_we) btb_vld_q[ex_idx] <= 1'b1;
      if (br_we) begin
        bht_q[ex_idx]   <= bht_d;
        lpht_q[ex_lidx] <= lpht_d;
        gpht_q[ex_gidx] <= gpht_d;
        tour_q[ex_idx]  <= tour_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[ex_idx] <= ex_pc[31:S_PC+2];
      btb_tgt_q[ex_idx] <= ex_target;
    end
  end

`ifdef BRANCH_PREDICT_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);

  logic [31:0]   ras_q [RAS_DEPTH];
  logic [RW-1:0] ras_tos_q, ras_tos_d, ras_wptr;
  logic [RW:0]   ras_cnt_q, ras_cnt_d;
  logic          rd_link, rs1_link, if_push, if_swap, if_ret, ras_we;
  logic          unused_ok;

  assign rd_link  = (if_instr[11:7] == 5'd1) || (if_instr[11:7] == 5'd5);
  assign rs1_link = (if_instr[19:15] == 5'd1) || (if_instr[19:15] == 5'd5);
  assign if_swap  = if_valid && (if_instr[6:0] == OP_JALR) && rd_link && rs1_link;
  assign if_push  = if_valid && if_jmp && rd_link && !if_swap;
  assign if_ret   = if_valid && (if_instr[6:0] == OP_JALR) && rs1_link && !rd_link;
  assign ras_hit  = if_ret && (ras_cnt_q != '0);
  assign ras_top  = ras_q[ras_tos_q];
  assign unused_ok = ^{if_instr[31:20], if_instr[14:12]};

  // a push on a full stack overwrites the oldest slot, which sits just above TOS
  always_comb begin
    ras_tos_d = ras_tos_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_wptr  = ras_tos_q;
    if (!stall) begin
      if (if_push) begin
        ras_tos_d = ras_tos_q + 1'b1;
        ras_wptr  = ras_tos_q + 1'b1;
        ras_we    = 1'b1;
        if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + 1'b1;
      end else if (if_swap) begin
        ras_we = 1'b1;
      end else if (ras_hit) begin
        ras_tos_d = ras_tos_q - 1'b1;
        ras_cnt_d = ras_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_tos_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_tos_q <= ras_tos_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_wptr] <= if_pc + 32'd4;
  end
`else
  logic unused_ok;
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
  assign unused_ok = ^{if_instr[31:7], RAS_DEPTH[0]};
`endif

endmodule

// File: tb/tb_branch_predict_tage_lite.sv
// Bench for branch_predict_tage_lite: directed scenarios plus randomized traffic
// checked against an array-based reference model of the prediction/update rules.
module tb_branch_predict_tage_lite;

  localparam int SPC = 6, SBH = 6, SG = 8, RD = 8;
  localparam int NPC = 1 << SPC, NBH = 1 << SBH, NG = 1 << SG;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;

  logic clk, reset_n, stall, if_valid, pred_taken, pred_local, pred_global;
  logic [31:0] if_pc, if_instr, pred_target, ex_pc, ex_target, ex_pred_target, redirect_pc;
  logic [SBH-1:0] pred_ghr, ex_ghr;
  logic ex_valid, ex_taken, ex_pred_taken, ex_pred_local, ex_pred_global, mispredict;
  logic [6:0] ex_opcode;

  branch_predict_tage_lite #(.S_PC(SPC), .S_BH(SBH), .S_GPHT(SG), .RAS_DEPTH(RD)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_local(pred_local), .pred_global(pred_global), .pred_ghr(pred_ghr),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_pred_local(ex_pred_local), .ex_pred_global(ex_pred_global), .ex_ghr(ex_ghr),
    .mispredict(mispredict), .redirect_pc(redirect_pc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit use_model = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state: plain integers, counters 0..3
  int          m_vld [NPC];
  logic [31:0] m_tag [NPC];
  logic [31:0] m_tgt [NPC];
  int          m_bht [NPC];
  int          m_tour[NPC];
  int          m_lpht[NPC*NBH];
  int          m_gpht[NG];
  int          m_ghr;

  function automatic int sat(input int c, input bit up);
    return up ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
  endfunction
  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NPC);
  endfunction
  function automatic int gidx_of(input logic [31:0] pc, input int h);
    return int'((pc >> 2) % NG) ^ h;
  endfunction
  function automatic bit is_jmp(input logic [6:0] op);
    return (op == JAL) || (op == JALR);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPC; i++) begin m_vld[i] = 0; m_bht[i] = 0; m_tour[i] = 1; end
    for (int i = 0; i < NPC*NBH; i++) m_lpht[i] = 1;
    for (int i = 0; i < NG; i++) m_gpht[i] = 1;
    m_ghr = 0;
  endtask

  task automatic model_pred(output bit t, output logic [31:0] tg, output bit l, output bit g, output bit hit);
    int i;
    i   = idx_of(if_pc);
    hit = (m_vld[i] != 0) && (m_tag[i] == (if_pc >> (SPC + 2)));
    l   = m_lpht[i*NBH + m_bht[i]] >= 2;
    g   = m_gpht[gidx_of(if_pc, m_ghr)] >= 2;
    t   = 1'b0;
    if (if_valid && hit) begin
      if (is_jmp(if_instr[6:0])) t = 1'b1;
      else if (if_instr[6:0] == BR) t = (m_tour[i] >= 2) ? g : l;
    end
    tg = t ? m_tgt[i] : if_pc + 4;
  endtask

  function automatic bit model_mp();
    return ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
  endfunction

  task automatic model_commit();
    bit t, l, g, hit, mp;
    logic [31:0] tg;
    int e, nghr;
    if (stall) return;
    model_pred(t, tg, l, g, hit);
    mp   = model_mp();
    nghr = m_ghr;
    if (mp && ex_opcode == BR)                     nghr = (int'(ex_ghr) * 2 + int'(ex_taken)) % NBH;
    else if (mp && is_jmp(ex_opcode))              nghr = int'(ex_ghr);
    else if (if_valid && if_instr[6:0] == BR && hit) nghr = (m_ghr * 2 + int'(t)) % NBH;
    if (ex_valid) begin
      e = idx_of(ex_pc);
      if (is_jmp(ex_opcode) || (ex_opcode == BR && ex_taken)) begin
        m_vld[e] = 1; m_tag[e] = ex_pc >> (SPC + 2); m_tgt[e] = ex_target;
      end
      if (ex_opcode == BR) begin
        m_lpht[e*NBH + m_bht[e]] = sat(m_lpht[e*NBH + m_bht[e]], ex_taken);
        m_gpht[gidx_of(ex_pc, int'(ex_ghr))] = sat(m_gpht[gidx_of(ex_pc, int'(ex_ghr))], ex_taken);
        if (ex_pred_global == ex_taken && ex_pred_local != ex_taken) m_tour[e] = sat(m_tour[e], 1'b1);
        else if (ex_pred_local == ex_taken && ex_pred_global != ex_taken) m_tour[e] = sat(m_tour[e], 1'b0);
        m_bht[e] = (m_bht[e] * 2 + int'(ex_taken)) % NBH;
      end
    end
    m_ghr = nghr;
  endtask

  // compare all outputs against the model, then advance one clock
  task automatic cyc();
    bit t, l, g, hit;
    logic [31:0] tg;
    #1;
    if (use_model) begin
      model_pred(t, tg, l, g, hit);
      chk("pred_taken", pred_taken, t);
      chk("pred_target", pred_target, tg);
      chk("pred_local", pred_local, l);
      chk("pred_global", pred_global, g);
      chk("pred_ghr", pred_ghr, m_ghr);
      chk("mispredict", mispredict, model_mp());
      chk("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 4);
    end
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_in();
    stall = 0; if_valid = 0; if_pc = 32'h100; if_instr = {25'b0, ALU};
    ex_valid = 0; ex_pc = 0; ex_opcode = ALU; ex_taken = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0; ex_pred_local = 0; ex_pred_global = 0; ex_ghr = 0;
  endtask

  task automatic set_if(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1);
    if_valid = 1; if_pc = pc; if_instr = {12'h0, rs1, 3'b000, rd, op};
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [6:0] op, input bit t, input logic [31:0] tg,
                        input bit pt, input logic [31:0] ptg, input bit pl, input bit pg, input logic [SBH-1:0] h);
    ex_valid = 1; ex_pc = pc; ex_opcode = op; ex_taken = t; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg; ex_pred_local = pl; ex_pred_global = pg; ex_ghr = h;
  endtask

  task automatic do_reset();
    reset_n = 0; idle_in(); model_reset();
    @(posedge clk); @(negedge clk);
    reset_n = 1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return ($urandom_range(0, 1) ? 32'h1000 : 32'h5000) + 32'(4 * $urandom_range(0, 7));
  endfunction
  function automatic logic [6:0] rnd_op();
    case ($urandom_range(0, 4))
      0, 1:    return BR;
      2:       return JAL;
      3:       return JALR;
      default: return ALU;
    endcase
  endfunction

  task automatic rand_in();
    logic [4:0] rd, rs1;
    logic [6:0] op;
    rd = 5'($urandom); rs1 = 5'($urandom);
`ifdef BRANCH_PREDICT_RAS_EN
    rd = 5'd0; rs1 = 5'd0;
`endif
    stall = ($urandom_range(0, 7) == 0);
    if_valid = ($urandom_range(0, 3) != 0);
    if_pc = rnd_pc();
    if_instr = {12'($urandom), rs1, 3'b000, rd, rnd_op()};
    op = rnd_op();
    ex_valid = ($urandom_range(0, 3) != 0);
    ex_pc = rnd_pc(); ex_opcode = op;
    ex_taken = is_jmp(op) ? 1'b1 : 1'($urandom);
    ex_target = 32'h1000 + 32'(4 * $urandom_range(0, 15));
    ex_pred_taken = 1'($urandom);
    ex_pred_target = $urandom_range(0, 1) ? ex_target : ex_pc + 4;
    ex_pred_local = 1'($urandom); ex_pred_global = 1'($urandom);
    ex_ghr = SBH'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit p_t, p_l, p_g, t;
    logic [31:0] p_tg;
    logic [SBH-1:0] p_h;
    reset_n = 0; idle_in(); model_reset();
    @(negedge clk);
    // reset held, inputs idle
    set_if(32'h100, BR, 5'd0, 5'd0);
    #1;
    chk("rst_taken", pred_taken, 0);
    chk("rst_target", pred_target, 32'h104);
    chk("rst_mp", mispredict, 0);
    chk("rst_ghr", pred_ghr, 0);
    @(negedge clk);
    reset_n = 1;
    idle_in();
    set_if(32'h100, BR, 5'd0, 5'd0);
    #1;
    chk("cold_taken", pred_taken, 0);
    chk("cold_target", pred_target, 32'h104);
    cyc();

    // branch at 0x200 learns taken to 0x180
    do_reset();
    set_ex(32'h200, BR, 1, 32'h180, 0, 32'h204, 0, 0, 6'd0);
    #1;
    chk("br_mp", mispredict, 1);
    chk("br_redirect", redirect_pc, 32'h180);
    cyc();
    for (int k = 0; k < 2; k++) begin
      set_ex(32'h200, BR, 1, 32'h180, 1, 32'h180, 0, 1, 6'd1);
      #1;
      chk("br_nomp", mispredict, 0);
      cyc();
    end
    idle_in();
    set_if(32'h200, BR, 5'd0, 5'd0);
    #1;
    chk("br_learn_taken", pred_taken, 1);
    chk("br_learn_target", pred_target, 32'h180);
    cyc();

    // alternating T/N branch
    do_reset();
    for (int i = 0; i < 40; i++) begin
      t = (i % 2 == 0);
      idle_in();
      set_if(32'h240, BR, 5'd0, 5'd0);
      #1;
      p_t = pred_taken; p_tg = pred_target; p_l = pred_local; p_g = pred_global; p_h = pred_ghr;
      if (i >= 30) chk("alt_global", pred_global, t);
      cyc();
      idle_in();
      set_ex(32'h240, BR, t, t ? 32'h100 : 32'h244, p_t, p_tg, p_l, p_g, p_h);
      cyc();
    end

    // repair has priority over a same-cycle speculative shift
    do_reset();
    set_ex(32'h300, JAL, 1, 32'h400, 0, 32'h304, 0, 0, 6'd0);
    cyc();
    idle_in();
    set_if(32'h300, BR, 5'd0, 5'd0);
    set_ex(32'h504, BR, 1, 32'h600, 0, 32'h508, 0, 0, 6'd0);
    cyc();
    idle_in();
    #1;
    chk("ghr_repair", pred_ghr, 6'b000001);
    cyc();
    set_if(32'h300, BR, 5'd0, 5'd0);
    cyc();
    idle_in();
    #1;
    chk("ghr_shift", pred_ghr, 6'b000010);
    cyc();

    // stall freezes state but mispredict stays live
    do_reset();
    stall = 1;
    set_if(32'h208, BR, 5'd0, 5'd0);
    set_ex(32'h208, BR, 1, 32'h280, 0, 32'h20c, 0, 1, 6'd3);
    #1;
    chk("stall_mp", mispredict, 1);
    chk("stall_redirect", redirect_pc, 32'h280);
    cyc();
    idle_in();
    set_if(32'h208, BR, 5'd0, 5'd0);
    #1;
    chk("stall_btb", pred_taken, 0);
    chk("stall_ghr", pred_ghr, 0);
    cyc();

`ifdef BRANCH_PREDICT_RAS_EN
    do_reset();
    use_model = 1'b0;
    for (int k = 0; k < 9; k++) begin
      set_if(32'h1000 + 32'(8 * k), JAL, 5'd1, 5'd0);
      cyc();
    end
    for (int j = 0; j < 9; j++) begin
      set_if(32'h3000, JALR, 5'd0, 5'd1);
      #1;
      if (j < 8) begin
        chk("ras_taken", pred_taken, 1);
        chk("ras_target", pred_target, 32'h1044 - 32'(8 * j));
      end else begin
        chk("ras_empty_taken", pred_taken, 0);
        chk("ras_empty_target", pred_target, 32'h3004);
      end
      cyc();
    end
    use_model = 1'b1;
`endif

    // randomized traffic with a mid-stream reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      rand_in();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
